// File: rtl/ps2_ascii_decoder.sv
// ps2_ascii_decoder
//   Receives PS/2 keyboard frames, decodes Set-2 scan codes into ASCII and
//   issues one character strobe per key press to a downstream text writer.
//   A one-character holding register absorbs keys arriving while the writer
//   is busy; the newest key overwrites an older unissued one.
//
// Parameters
//   TIMEOUT_CYCLES : clk cycles without a PS/2 falling edge mid-frame before
//                    the partial frame is abandoned.
//   SYNC_STAGES    : synchronizer depth on ps2_clk / ps2_data (>= 2).
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   ps2_clk   in   PS/2 clock from keyboard (asynchronous)
//   ps2_data  in   PS/2 data from keyboard (asynchronous)
//   done      in   writer idle flag, 1 = may accept a character
//   data_in   out  one-clk strobe, character valid
//   ascii     out  character code, held until the next strobe
//   frame_err out  one-clk pulse on a rejected frame
module ps2_ascii_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       done,
    output logic       data_in,
    output logic [7:0] ascii,
    output logic       frame_err
);

    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimeoutW-1:0] TimeoutMax = TimeoutW'(TIMEOUT_CYCLES);

    localparam logic [7:0] CodeExt    = 8'hE0;
    localparam logic [7:0] CodeBreak  = 8'hF0;
    localparam logic [7:0] CodeShiftL = 8'h12;
    localparam logic [7:0] CodeShiftR = 8'h59;

    // Synchronizers and edge detect
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   ps2_clk_prev_q;
    logic                   ps2_clk_s;
    logic                   ps2_data_s;
    logic                   fall;

    // Receive state
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [10:0]         shift_q, shift_d;
    logic [TimeoutW-1:0] timeout_q, timeout_d;

    // Code state
    logic brk_q, brk_d;
    logic ext_q, ext_d;
    logic shl_q, shl_d;
    logic shr_q, shr_d;

    // Issue state
    logic       pending_q, pending_d;
    logic [7:0] pend_char_q, pend_char_d;
    logic       data_in_q, data_in_d;
    logic [7:0] ascii_q, ascii_d;
    logic       frame_err_q, frame_err_d;

    // Frame evaluation
    logic [10:0] frame_next;
    logic        frame_done;
    logic        frame_ok;
    logic        byte_valid;
    logic [7:0]  rx_byte;
    logic        char_valid;
    logic [7:0]  char_code;
    logic        issue;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign fall       = ps2_clk_prev_q & ~ps2_clk_s;

    // Bits arrive LSB first, so new bits enter at the top and the start bit
    // ends up in bit 0 once all 11 are in.
    assign frame_next = {ps2_data_s, shift_q[10:1]};
    assign frame_done = fall && (bit_cnt_q == 4'd10);
    assign frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);
    assign byte_valid = frame_done & frame_ok;
    assign rx_byte    = frame_next[8:1];

    // Waiting one cycle after a strobe lets a writer that samples on the
    // opposite edge drop done before we look at it again.
    assign issue = pending_q & done & ~data_in_q;

    // Returns {hit, char}; a zero char means unmapped.
    function automatic logic [8:0] map_code(input logic [7:0] code, input logic upper);
        logic [7:0] ch;
        ch = 8'h00;
        case (code)
            8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
            8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
            8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
            8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
            8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
            8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
            8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;
            8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;
            8'h3E: ch = 8'h38;  8'h46: ch = 8'h39;
            8'h29: ch = 8'h20;
            8'h66: ch = 8'h08;
            8'h5A: ch = 8'h0D;
            default: ch = 8'h00;
        endcase
        // Only letters react to shift.
        if (upper && (ch >= 8'h61) && (ch <= 8'h7A)) begin
            ch = ch - 8'h20;
        end
        return {(ch != 8'h00), ch};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q     <= '1;
            data_sync_q    <= '1;
            ps2_clk_prev_q <= 1'b1;
            bit_cnt_q      <= 4'd0;
            shift_q        <= 11'd0;
            timeout_q      <= '0;
            brk_q          <= 1'b0;
            ext_q          <= 1'b0;
            shl_q          <= 1'b0;
            shr_q          <= 1'b0;
            pending_q      <= 1'b0;
            pend_char_q    <= 8'h00;
            data_in_q      <= 1'b0;
            ascii_q        <= 8'h00;
            frame_err_q    <= 1'b0;
        end else begin
            clk_sync_q     <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q    <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            ps2_clk_prev_q <= ps2_clk_s;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            timeout_q      <= timeout_d;
            brk_q          <= brk_d;
            ext_q          <= ext_d;
            shl_q          <= shl_d;
            shr_q          <= shr_d;
            pending_q      <= pending_d;
            pend_char_q    <= pend_char_d;
            data_in_q      <= data_in_d;
            ascii_q        <= ascii_d;
            frame_err_q    <= frame_err_d;
        end
    end

    // Next-state: receiver and timeout
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        timeout_d   = timeout_q;
        frame_err_d = frame_done & ~frame_ok;
        if (fall) begin
            // An edge always beats a coincident timeout.
            timeout_d = '0;
            if (frame_done) begin
                bit_cnt_d = 4'd0;
                shift_d   = 11'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = frame_next;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (timeout_q == TimeoutMax) begin
                bit_cnt_d = 4'd0;
                shift_d   = 11'd0;
                timeout_d = '0;
            end else begin
                timeout_d = timeout_q + 1'b1;
            end
        end else begin
            timeout_d = '0;
        end
    end

    // Next-state: scan-code decoder and issue handshake
    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        shl_d       = shl_q;
        shr_d       = shr_q;
        char_valid  = 1'b0;
        char_code   = 8'h00;
        pending_d   = pending_q;
        pend_char_d = pend_char_q;
        data_in_d   = 1'b0;
        ascii_d     = ascii_q;

        if (byte_valid) begin
            if (rx_byte == CodeExt) begin
                ext_d = 1'b1;
            end else if (rx_byte == CodeBreak) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                if (rx_byte == CodeShiftL) shl_d = 1'b0;
                if (rx_byte == CodeShiftR) shr_d = 1'b0;
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (ext_q) begin
                ext_d = 1'b0;
            end else if (rx_byte == CodeShiftL) begin
                shl_d = 1'b1;
            end else if (rx_byte == CodeShiftR) begin
                shr_d = 1'b1;
            end else begin
                {char_valid, char_code} = map_code(rx_byte, shl_q | shr_q);
            end
        end

        if (issue) begin
            data_in_d = 1'b1;
            ascii_d   = pend_char_q;
            pending_d = 1'b0;
        end
        // A newly decoded character wins over both issue and an older pending.
        if (char_valid) begin
            pending_d   = 1'b1;
            pend_char_d = char_code;
        end
    end

    // Outputs
    always_comb begin
        data_in   = data_in_q;
        ascii     = ascii_q;
        frame_err = frame_err_q;
    end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// tb_ps2_ascii_decoder
//   Self-checking bench for ps2_ascii_decoder: directed scenarios followed by
//   random key sequences checked against a scan-code reference model.
module tb_ps2_ascii_decoder;

    localparam int unsigned To = 400;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       done;
    logic       data_in;
    logic [7:0] ascii;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_ascii_decoder #(
        .TIMEOUT_CYCLES(To),
        .SYNC_STAGES   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .done     (done),
        .data_in  (data_in),
        .ascii    (ascii),
        .frame_err(frame_err)
    );

    int total = 0;
    int bad   = 0;

    // Output monitor
    int   strobe_cnt = 0;
    int   err_cycles = 0;
    int   dbl_cnt    = 0;
    logic prev_di    = 1'b0;

    always @(negedge clk) begin
        if (data_in) begin
            strobe_cnt <= strobe_cnt + 1;
            if (prev_di) dbl_cnt <= dbl_cnt + 1;
        end
        if (frame_err) err_cycles <= err_cycles + 1;
        prev_di <= data_in;
    end

    // Reference model
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46};
    logic [7:0] pool [43];

    bit         m_brk, m_ext, m_shl, m_shr, m_pend_v;
    logic [7:0] m_pend;
    int         exp_strobes = 0;
    logic [7:0] exp_ascii   = 8'h00;

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_shl = 0; m_shr = 0; m_pend_v = 0; m_pend = 8'h00;
        exp_ascii = 8'h00;
    endtask

    task automatic model_map(input logic [7:0] code, input bit up, output bit hit,
                             output logic [7:0] ch);
        hit = 0;
        ch  = 8'h00;
        for (int i = 0; i < 26; i++)
            if (letters[i] == code) begin hit = 1; ch = (up ? 8'h41 : 8'h61) + 8'(i); end
        for (int i = 0; i < 10; i++)
            if (digits[i] == code) begin hit = 1; ch = 8'h30 + 8'(i); end
        if (code == 8'h29) begin hit = 1; ch = 8'h20; end
        if (code == 8'h66) begin hit = 1; ch = 8'h08; end
        if (code == 8'h5A) begin hit = 1; ch = 8'h0D; end
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit         hit;
        logic [7:0] ch;
        hit = 0;
        ch  = 8'h00;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (m_brk) begin
            if (b == 8'h12) m_shl = 0;
            if (b == 8'h59) m_shr = 0;
            m_brk = 0;
            m_ext = 0;
        end else if (m_ext) m_ext = 0;
        else if (b == 8'h12) m_shl = 1;
        else if (b == 8'h59) m_shr = 1;
        else model_map(b, m_shl | m_shr, hit, ch);
        if (hit) begin
            if (done) begin exp_strobes++; exp_ascii = ch; end
            else begin m_pend_v = 1; m_pend = ch; end
        end
    endtask

    task automatic model_done_rise();
        if (m_pend_v) begin exp_strobes++; exp_ascii = m_pend; m_pend_v = 0; end
    endtask

    // Stimulus helpers
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (5) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (5) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic send_key(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
        model_byte(b);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_strobes"}, strobe_cnt, exp_strobes);
        check({tag, "_ascii"}, {24'd0, ascii}, {24'd0, exp_ascii});
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int base;
        int ebase;
        int k;
        logic [7:0] code;

        for (int i = 0; i < 26; i++) pool[i] = letters[i];
        for (int i = 0; i < 10; i++) pool[26 + i] = digits[i];
        pool[36] = 8'h29; pool[37] = 8'h66; pool[38] = 8'h5A;
        pool[39] = 8'h12; pool[40] = 8'h59; pool[41] = 8'h76; pool[42] = 8'h0D;

        model_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        done     = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_in", {31'd0, data_in}, 0);
        check("rst_ascii", {24'd0, ascii}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Press a
        base = strobe_cnt;
        send_key(8'h1C);
        settle();
        check("a_strobes", strobe_cnt - base, 1);
        check("a_ascii", {24'd0, ascii}, 32'h61);
        check("a_err", err_cycles, 0);

        // Shift+a, then plain a
        base = strobe_cnt;
        send_key(8'h12); send_key(8'h1C); send_key(8'hF0); send_key(8'h1C);
        send_key(8'hF0); send_key(8'h12);
        settle();
        check("shift_a_strobes", strobe_cnt - base, 1);
        check("shift_a_ascii", {24'd0, ascii}, 32'h41);
        send_key(8'h1C);
        settle();
        check("unshift_a_ascii", {24'd0, ascii}, 32'h61);

        // Typematic repeat
        base = strobe_cnt;
        send_key(8'h1C); send_key(8'h1C);
        settle();
        check("repeat_strobes", strobe_cnt - base, 2);

        // Releases and extended keys
        base = strobe_cnt;
        send_key(8'hF0); send_key(8'h1C); send_key(8'hE0); send_key(8'h75);
        settle();
        check("release_strobes", strobe_cnt - base, 0);
        check("release_ascii", {24'd0, ascii}, 32'h61);

        // Bad parity frame
        base  = strobe_cnt;
        ebase = err_cycles;
        send_frame(8'h1C, 1'b1, 11);
        settle();
        check("bad_err", err_cycles - ebase, 1);
        check("bad_strobes", strobe_cnt - base, 0);
        send_key(8'h16);
        settle();
        check("after_bad_ascii", {24'd0, ascii}, 32'h31);
        check("after_bad_err", err_cycles - ebase, 1);

        // Busy writer: last key wins
        done = 1'b0;
        base = strobe_cnt;
        send_key(8'h66); send_key(8'h5A);
        settle();
        check("busy_strobes", strobe_cnt - base, 0);
        check("busy_ascii_held", {24'd0, ascii}, 32'h31);
        done = 1'b1;
        model_done_rise();
        repeat (5) @(posedge clk);
        #1;
        check("busy_release_strobes", strobe_cnt - base, 1);
        check("busy_release_ascii", {24'd0, ascii}, 32'h0D);

        // Stalled frame, then full frame
        send_frame(8'h5A, 1'b0, 5);
        repeat (To + 50) @(posedge clk);
        base  = strobe_cnt;
        ebase = err_cycles;
        send_key(8'h29);
        settle();
        check("stall_ascii", {24'd0, ascii}, 32'h20);
        check("stall_strobes", strobe_cnt - base, 1);
        check("stall_err", err_cycles - ebase, 0);

        // Reset mid-frame
        send_frame(8'h1C, 1'b0, 5);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_data_in", {31'd0, data_in}, 0);
        check("midrst_ascii", {24'd0, ascii}, 0);
        model_reset();
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        base  = strobe_cnt;
        ebase = err_cycles;
        send_key(8'h45);
        settle();
        check("midrst_next_ascii", {24'd0, ascii}, 32'h30);
        check("midrst_next_strobes", strobe_cnt - base, 1);
        check("midrst_next_err", err_cycles - ebase, 0);

        // Reset with a pending character
        done = 1'b0;
        send_key(8'h1C);
        #3 rst_n = 1'b0;
        #1;
        check("pendrst_ascii", {24'd0, ascii}, 0);
        model_reset();
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        base  = strobe_cnt;
        done  = 1'b1;
        model_done_rise();
        repeat (20) @(posedge clk);
        #1;
        check("pendrst_strobes", strobe_cnt - base, 0);
        check("pendrst_ascii_after", {24'd0, ascii}, 0);

        // Random key sequences against the model
        exp_strobes = strobe_cnt;
        for (int i = 0; i < 40; i++) begin
            k    = $urandom_range(0, 9);
            code = pool[$urandom_range(0, 42)];
            if (k < 3) send_key(8'hF0);
            else if (k == 3) send_key(8'hE0);
            send_key(code);
            settle();
            check_model($sformatf("rand%0d", i));
        end

        check("double_strobes", dbl_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_ascii_decoder.md
Name: ps2_ascii_decoder

Overview:
- Receives PS/2 keyboard frames, decodes Set-2 scan codes into ASCII and issues one character strobe per key press.
- Sits directly upstream of the VRAM text-input writer. Drives that writer's data_in strobe and ascii byte, and reads back its done flag.
- One-character holding buffer absorbs keys that arrive while the writer is busy.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles without a PS/2 falling edge mid-frame before the frame is abandoned.
- SYNC_STAGES, 2: synchronizer depth on ps2_clk and ps2_data.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- ps2_clk  input  1  PS/2 clock from keyboard, asynchronous.
- ps2_data  input  1  PS/2 data from keyboard, asynchronous.
- done  input  1  writer idle flag; 1 means it may accept a character.
- data_in  output  1  one-clk strobe, character valid.
- ascii  output  8  character code; held stable until the next strobe.
- frame_err  output  1  one-clk pulse on a rejected frame.

Behaviour:
- Reset (rst_n=0, asynchronous) clears:
  - outputs: data_in=0, ascii=8'h00, frame_err=0;
  - state: bit counter=0, shift register=0, timeout counter=0, break_flag=0, ext_flag=0, shift_l=0, shift_r=0, pending=0;
  - synchronizer flops are set to 1.
- Reset mid-frame discards the partial frame and any pending character.
- Receive path:
  - Synchronize ps2_clk and ps2_data through SYNC_STAGES flops. A falling edge is synced ps2_clk going 1->0 between consecutive clk cycles.
  - On each falling edge, shift ps2_data into an 11-bit frame, LSB first: start, d0..d7, parity, stop. Increment the bit counter.
  - After the 11th bit, the frame is valid only if start=0, stop=1, and d0..d7 plus parity has an odd count of ones.
  - Invalid frame: pulse frame_err for 1 clk, produce no code, clear the bit counter.
  - Timeout counter: runs while the bit counter is nonzero and resets on every falling edge. When it reaches TIMEOUT_CYCLES, clear the bit counter and shift register. No frame_err pulse on timeout.
- Code state machine, applied to each valid byte:
  - E0: set ext_flag.
  - F0: set break_flag.
  - Otherwise, if break_flag=1, the byte is a release:
    - 12 clears shift_l; 59 clears shift_r.
    - Clear break_flag and ext_flag. No character.
  - Otherwise, if ext_flag=1: clear ext_flag, no character (extended keys unmapped).
  - Otherwise, the byte is a make:
    - 12 sets shift_l; 59 sets shift_r.
    - Any other byte is looked up in the table below.
  - Typematic repeats of a make code produce repeated characters.
- Mapping table:
  - Letters give lowercase 8'h61..8'h7A, or uppercase 8'h41..8'h5A when shift_l|shift_r. Codes for a..z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - Digits 0..9: 45 16 1E 26 25 2E 36 3D 3E 46 give 8'h30..8'h39; shift has no effect.
  - 29 gives 8'h20 (space), 66 gives 8'h08 (backspace), 5A gives 8'h0D (enter).
  - Unmapped make codes produce nothing.
- Issue handshake:
  - A mapped character goes into the pending register (pending=1).
  - If pending=1 and the character is newer, it overwrites pending: last key wins, older one dropped.
  - When pending=1, done=1 and data_in was 0 in the previous cycle: drive ascii from pending, pulse data_in for exactly 1 clk, clear pending.
  - The one-cycle guard covers the writer sampling on the opposite clock edge.
  - ascii is held unchanged after the strobe, for the writer's full multi-cycle write, until the next issue.
- Simultaneous events:
  - A new character decoded in the same cycle pending is issued lands in pending (pending stays 1). It issues when done returns to 1.
  - A falling edge in the same cycle as a timeout: the edge wins and the timeout counter clears.
- Latency: 1 clk from the 11th falling edge (synced) to pending, plus 1 clk to data_in when done=1.

Test Plan:
- Press a: frame 0x1C (parity 0) with done=1 -> one data_in pulse, ascii=8'h61, frame_err=0.
- Shift+a: frames 12, 1C, F0 1C, F0 12 -> exactly one strobe, ascii=8'h41; afterwards 1C alone -> 8'h61.
- Release: F0 followed by 0x1C -> no data_in; E0 75 -> no data_in.
- Bad frame: frame 0x1C with parity=1 -> frame_err 1 clk, no data_in. Next good 0x16 -> ascii=8'h31.
- Busy writer: hold done=0, send 0x66 then 0x5A -> no strobe while done=0. Raise done -> one strobe, ascii=8'h0D; 8'h08 dropped.
- Stalled frame: 5 falling edges, then ps2_clk idle for TIMEOUT_CYCLES -> bit counter cleared. A following full 0x29 frame -> ascii=8'h20.
- Reset mid-frame or with pending=1 -> all outputs 0, nothing issued after release.
